// File: rtl/spi_slave_responder.sv
// Mode-0 SPI target oversampled in the clk_i domain with a one-entry transmit holding register.
// Define SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB-first; MSB-first otherwise.
module spi_slave_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_cs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_accept_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, prime_q;
  logic                   sclk_d1_q, cs_d1_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_e     state_q, state_d;
  logic [7:0] shift_tx_q, shift_tx_d;
  logic [7:0] shift_rx_q, shift_rx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic       armed_q, armed_d;

  logic       reload;
  logic       tx_write;
  logic [7:0] rx_next, tx_shifted;
  logic       tx_bit;

  // prime_q fills with ones as the synchronisers refill from the pins, so the
  // reset-value high on cs is never mistaken for a real deselect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      prime_q     <= '0;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d1_q   <= sclk_s;
      cs_d1_q     <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign cs_rise   = cs_s & ~cs_d1_q;
  assign cs_fall   = ~cs_s & cs_d1_q;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next    = {mosi_s, shift_rx_q[7:1]};
  assign tx_shifted = {1'b0, shift_tx_q[7:1]};
  assign tx_bit     = shift_tx_q[0];
`else
  assign rx_next    = {shift_rx_q[6:0], mosi_s};
  assign tx_shifted = {shift_tx_q[6:0], 1'b0};
  assign tx_bit     = shift_tx_q[7];
`endif

  assign tx_write = tx_valid_i & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    armed_d     = armed_q | (cs_s & prime_q[SYNC_STAGES-1]);
    reload      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 3'd0;
          reload    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Deselect takes priority over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_rx_d = rx_next;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == 3'd0) reload = 1'b1;
          else                   shift_tx_d = tx_shifted;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reload only clears a full register and a write only fills an empty one,
    // so the two never fight over hold_full_d.
    if (reload) begin
      if (hold_full_q) begin
        shift_tx_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shift_tx_d = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end
    if (tx_write) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shift_tx_q  <= IDLE_BYTE;
      shift_rx_q  <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      armed_q     <= armed_d;
    end
  end

  assign busy_o        = (state_q == ST_ACTIVE);
  assign spi_miso_en_o = (state_q == ST_ACTIVE);
  assign spi_miso_o    = (state_q == ST_ACTIVE) ? tx_bit : 1'b1;
  assign tx_accept_o   = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

Oversampled SPI mode-0 target (responder) for the opposite end of the board's SPI master link: it receives bytes clocked in by an external master and returns bytes supplied by the local core on MISO. It runs entirely in the system clock domain, resynchronising the asynchronous SPI pins. It exposes a one-entry transmit holding register with valid/accept handshake and a one-cycle receive strobe. It sits beside the SD/SPI pins in the FPGA top and lets the board act as a SPI peripheral for test rigs or a host.

## Interface
- SYNC_STAGES, 2: synchroniser flops on spi_clk_i/spi_cs_i/spi_mosi_i (min 2).
- IDLE_BYTE, 8'hFF: byte shifted out when no transmit data is pending.

- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- spi_clk_i  input  1  SPI clock from master, CPOL=0.
- spi_cs_i  input  1  chip select, active-low.
- spi_mosi_i  input  1  master-out data.
- spi_miso_o  output  1  target-out data.
- spi_miso_en_o  output  1  MISO output enable (tristate control at top level).
- tx_data_i  input  8  next byte to transmit.
- tx_valid_i  input  1  tx_data_i valid.
- tx_accept_o  output  1  holding register empty; write occurs when tx_valid_i & tx_accept_o.
- rx_data_o  output  8  last complete received byte (held until next).
- rx_valid_o  output  1  one-cycle pulse, rx_data_o updated.
- tx_underrun_o  output  1  one-cycle pulse, IDLE_BYTE substituted.
- busy_o  output  1  high while in ACTIVE state.

## Operation
- Reset values: spi_miso_o=1, spi_miso_en_o=0, tx_accept_o=1, rx_data_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0; synchronisers reset to sclk=0, cs=1, mosi=0; holding register empty; bit counter 0; armed=0.
- Edges: rise/fall of synchronised sclk and cs detected against one extra delay flop.
- armed sets once synchronised cs is seen high; ACTIVE entry requires armed (prevents mid-byte entry after reset with cs held low).
- FSM IDLE: miso_en=0, miso=1. On cs fall & armed -> ACTIVE: load shift_tx from holding register (clear it) or IDLE_BYTE (pulse tx_underrun_o); bit_cnt=0; miso_en=1; miso=shift_tx[7].
- ACTIVE, sclk rise: shift mosi into shift_rx, bit_cnt+1. On bit_cnt 7->0 wrap: rx_data_o <= assembled byte, rx_valid_o pulse next cycle.
- ACTIVE, sclk fall: if bit_cnt==0 (byte boundary) reload shift_tx as above, else shift shift_tx left; miso = new MSB.
- ACTIVE, cs rise -> IDLE: partial rx bits discarded (no rx_valid_o); in-flight tx byte lost; holding register untouched.
- cs rise and sclk edge in same cycle: cs rise wins, edge ignored.
- Holding register write and reload in same cycle: cannot coincide when full (accept=0); when empty, reload takes IDLE_BYTE (underrun) and the write fills the register for the next byte.
- rst_i mid-frame: immediate return to reset values; next frame only after cs observed high.

## Timing
- Pin-to-edge detect: SYNC_STAGES clk_i cycles after first clk_i edge sampling the new level; action registered on the following edge.
- rx_valid_o rises SYNC_STAGES+1 cycles after the 8th sclk rise is first sampled.
- MISO updates SYNC_STAGES+1 cycles after sclk fall is first sampled; master must hold each sclk phase ≥ SYNC_STAGES+3 clk_i cycles (f_sclk ≤ f_clk/10 at default).
- cs fall to first MISO bit valid: SYNC_STAGES+1 cycles; master waits ≥ SYNC_STAGES+3 cycles before first sclk rise.
- tx_accept_o is a registered flag; it falls the cycle after the accepting write and rises the cycle after a reload consumes the register.

## Configuration
- SPI_SLAVE_LSB_FIRST_EN: defined -> both shift registers LSB-first (rx shifts right inserting at bit 7; miso = shift_tx[0]). Undefined (default) -> MSB-first as above. Handshake, timing and counts unchanged.

## Test plan
- Reset with cs low: hold cs=0 through rst_i release, clock 8 sclk -> no rx_valid_o, busy_o=0; raise then drop cs -> normal frame.
- Preload tx 8'hA5, master sends 8'h3C -> rx_data_o=8'h3C with single rx_valid_o pulse; master reads 8'hA5; tx_accept_o back to 1.
- Empty holding register, 2-byte frame -> MISO shows 8'hFF,8'hFF; tx_underrun_o pulses twice.
- Back-to-back: write 8'h11 then 8'h22 after accept, 2-byte frame sending 8'hC3,8'h5A -> MISO 8'h11,8'h22; two rx pulses with 8'hC3,8'h5A.
- cs raised after 5 bits -> no rx_valid_o, busy_o=0, preloaded holding byte 8'h77 sent intact in next frame.
- With SPI_SLAVE_LSB_FIRST_EN, tx 8'h01, master MOSI sequence 1,0,0,0,0,0,0,0 -> first MISO bit 1, rx_data_o=8'h01.
